ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs plus its LED byte, or 0xFF reset.
- Complements the existing PS/2 keyboard receiver. Drives PS2_CLK and PS2_DATA open-drain through top-level tri-state buffers (line driven low when oe=1, released otherwise).
- Exposes a valid/ready byte interface, reports device ACK or timeout, and flags `busy` so the receiver path can ignore line activity during a send.

Parameters:
- FILTER_CYCLES, 8: consecutive identical synchronized samples needed to accept a PS/2 line level change.
- INHIBIT_CYCLES, 12000: clock-inhibit hold, 120 us at 100 MHz (protocol minimum is 100 us).
- START_TIMEOUT, 1500000: maximum wait from clock release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 200000: maximum time from the first device falling edge to the ACK edge (2 ms).

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS2_CLK pad input (asynchronous)
- ps2_data_in  in  1  raw PS2_DATA pad input (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse at end of a successful or NACKed frame
- tx_ack_ok  out  1  valid while tx_done is high; 1 = device ACKed (data low at ACK edge)
- tx_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset, synchronous and active-high on CLK100MHZ: state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_ack_ok=0, tx_error=0, busy=0, tx_ready=1. All counters cleared. Synchronizer and filter outputs preset to 1 (idle-high lines).
- Reset mid-frame releases both lines on the next edge; no pulses are emitted.
- Input conditioning: each of clk/data passes through a 2-FF synchronizer, then the FILTER_CYCLES stability filter. `fall` is a one-cycle pulse when the filtered clk goes 1 to 0.
- Frame contents: shift register = {stop=1, parity=~^tx_data, tx_data[7:0]}, sent LSB first. Parity is odd, e.g. 0xED gives parity 1, 0x01 gives parity 0.
- IDLE:
  - tx_ready=1.
  - On the handshake, latch the frame, clear the cycle counter, go to INHIBIT.
  - No new byte is accepted until the state returns to IDLE.
- INHIBIT:
  - ps2_clk_oe=1 for INHIBIT_CYCLES cycles.
  - On the final cycle also assert ps2_data_oe=1 (start bit), then go to RELEASE.
- RELEASE:
  - ps2_clk_oe=0, ps2_data_oe held 1.
  - Count up to START_TIMEOUT; reaching it goes to ERROR.
  - On `fall`, drive bit0 and go to SEND with edge count=1.
- SEND:
  - On each `fall`, increment the edge count. Edges 2..8 drive bits 1..7, edge 9 drives parity, edge 10 drives stop (ps2_data_oe=0).
  - ps2_data_oe = ~current_bit; updated exactly one cycle after `fall`.
  - On edge 11, sample filtered data: tx_ack_ok_reg = ~data. Go to WAIT_IDLE.
  - A frame counter runs from the first `fall`; reaching FRAME_TIMEOUT before edge 11 goes to ERROR.
- WAIT_IDLE:
  - Both oe=0.
  - When filtered clk=1 and data=1, pulse tx_done with tx_ack_ok, go to IDLE.
  - The FRAME_TIMEOUT counter keeps running here; expiry goes to ERROR.
- ERROR:
  - One cycle: both oe=0, tx_error=1, tx_done=0. Then go to IDLE.
- tx_done and tx_error are never high in the same cycle.
- tx_ack_ok holds its value until the next tx_done.
- Counters saturate at the compare value; no wrap-around.
- Device clock glitches shorter than FILTER_CYCLES cycles produce no `fall` and no bit advance.

Test Plan:
- Device BFM clocks at 12.5 kHz, send tx_data=0xED -> clk held low ≥12000 cycles; sampled bits on rising edges are 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; BFM ACKs low -> tx_done=1 with tx_ack_ok=1, tx_ready back to 1.
- Send 0x00, then 0xFF, back-to-back (tx_valid held) -> parity sampled 1 for both; the second byte is not accepted until after the first tx_done.
- BFM never clocks after release -> tx_error pulse exactly START_TIMEOUT cycles after clk release; both oe=0; no tx_done.
- BFM stops after 5 edges -> tx_error at FRAME_TIMEOUT after the first edge; tx_ready=1 on the following cycle.
- BFM leaves data high at edge 11 (NACK) -> tx_done=1, tx_ack_ok=0.
- Assert rst during SEND at edge 4 -> next cycle ps2_clk_oe=0, ps2_data_oe=0, busy=0, no tx_done/tx_error. Also inject 3-cycle glitches on clk -> bit count unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte per valid/ready handshake. It inhibits the bus clock,
// asserts the start bit, then shifts data/parity/stop on the device's falling
// clock edges. It reports the device ACK, or a timeout. PS2_CLK and PS2_DATA are
// open-drain: the *_oe outputs pull the line low through top-level tri-states.
module ps2_host_tx #(
    parameter int unsigned FILTER_CYCLES  = 8,
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned START_TIMEOUT  = 1500000,
    parameter int unsigned FRAME_TIMEOUT  = 200000
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);

    localparam int unsigned FW   = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned CMAX = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned TW   = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] INH_PRE    = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SEND,
        S_WAIT_IDLE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [9:0]    shreg;
    logic [CW-1:0] cnt;
    logic [TW-1:0] frame_cnt;
    logic [3:0]    edge_cnt;
    logic          ack_r;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_f, clk_f_d, data_f;
    logic [FW-1:0] clk_fcnt, data_fcnt;
    logic          fall;

    // Two-flop synchronizers for the asynchronous pad inputs; idle lines read high.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    // Clock line filter: accept a new level only after FILTER_CYCLES stable samples.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            clk_f    <= 1'b1;
            clk_f_d  <= 1'b1;
            clk_fcnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FILT_LAST) begin
                clk_f    <= clk_s2;
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + 1'b1;
            end
        end
    end

    // Data line filter, same rule as the clock filter.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            data_f    <= 1'b1;
            data_fcnt <= '0;
        end else begin
            if (data_s2 == data_f) begin
                data_fcnt <= '0;
            end else if (data_fcnt == FILT_LAST) begin
                data_f    <= data_s2;
                data_fcnt <= '0;
            end else begin
                data_fcnt <= data_fcnt + 1'b1;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // Transmit sequencer: all line controls and status outputs are registered here.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            frame_cnt   <= '0;
            edge_cnt    <= '0;
            ack_r       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_ack_ok   <= 1'b0;
            tx_error    <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg      <= {1'b1, ~^tx_data, tx_data};
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        tx_ready   <= 1'b0;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // Data is set one cycle early so it is low during the last held cycle.
                    if (cnt == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        state      <= S_RELEASE;
                    end else begin
                        if (cnt == INH_PRE) begin
                            ps2_data_oe <= 1'b1;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (fall) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b1, shreg[9:1]};
                        edge_cnt    <= 4'd1;
                        frame_cnt   <= TW'(1);
                        state       <= S_SEND;
                    end else if (cnt == START_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        state       <= S_ERROR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (frame_cnt == FRAME_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        state       <= S_ERROR;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (fall) begin
                            if (edge_cnt == 4'd10) begin
                                ack_r       <= ~data_f;
                                ps2_data_oe <= 1'b0;
                                state       <= S_WAIT_IDLE;
                            end else begin
                                ps2_data_oe <= ~shreg[0];
                                shreg       <= {1'b1, shreg[9:1]};
                                edge_cnt    <= edge_cnt + 4'd1;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (clk_f && data_f) begin
                        tx_done   <= 1'b1;
                        tx_ack_ok <= ack_r;
                        busy      <= 1'b0;
                        tx_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end else if (frame_cnt == FRAME_LAST) begin
                        tx_error <= 1'b1;
                        state    <= S_ERROR;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                S_ERROR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    tx_ready    <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    tx_ready    <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on wired-AND lines, with
// table-driven frames plus hand-written timeout, glitch and reset sequences.
module tb_ps2_host_tx;

    localparam int unsigned FILT = 8;
    localparam int unsigned INH  = 200;
    localparam int unsigned ST   = 3000;
    localparam int unsigned FT   = 1500;
    localparam int unsigned HP   = 40;

    logic       CLK100MHZ = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, tx_done, tx_ack_ok, tx_error;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .FILTER_CYCLES (FILT),
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST),
        .FRAME_TIMEOUT (FT)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_ack_ok  (tx_ack_ok),
        .tx_error   (tx_error)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned cyc = 0;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    // Event recorder: timestamps line releases and counts status pulses.
    logic        clk_oe_q = 1'b0;
    logic        data_oe_q = 1'b0;
    bit          first_fall_seen = 1'b0;
    int unsigned clk_rel_cyc = 0;
    int unsigned dat_fall_cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          overlap_cnt = 0;
    int          ready_busy_bad = 0;
    always @(negedge CLK100MHZ) begin
        if (!rst) begin
            if (clk_oe_q && !ps2_clk_oe) begin
                clk_rel_cyc     = cyc;
                first_fall_seen = 1'b0;
            end
            if (data_oe_q && !ps2_data_oe && !first_fall_seen) begin
                dat_fall_cyc    = cyc;
                first_fall_seen = 1'b1;
            end
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
            if (tx_done && tx_error) overlap_cnt++;
            if (tx_ready == busy) ready_busy_bad++;
        end
        clk_oe_q  = ps2_clk_oe;
        data_oe_q = ps2_data_oe;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic pulse_send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        check("ready before send", 32'(tx_ready), 1);
        tick();
        tx_valid = 1'b0;
    endtask

    // Measures the clock-inhibit phase and the start bit it leaves behind.
    task automatic wait_release(input string tag);
        int n = 0;
        int inh = 0;
        int dhi = 0;
        while (!ps2_clk_oe && n < 50) begin tick(); n++; end
        check({tag, " inhibit start"}, 32'(ps2_clk_oe), 1);
        while (ps2_clk_oe && inh < 2 * INH) begin
            inh++;
            if (ps2_data_oe) dhi++;
            tick();
        end
        check({tag, " inhibit length"}, inh, INH);
        check({tag, " start in last inhibit cycle"}, dhi, 1);
        check({tag, " data held at release"}, 32'(ps2_data_oe), 1);
        check({tag, " busy"}, 32'(busy), 1);
    endtask

    // One device clock period; data is sampled just before the rising edge.
    task automatic dev_cycle(output logic smp);
        dev_clk = 1'b0;
        repeat (HP) tick();
        smp = ps2_data_in;
        dev_clk = 1'b1;
        repeat (HP) tick();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] exp_byte, input logic exp_par,
                             input logic ack, input logic [7:0] next_data);
        logic [10:0] bits;
        logic        b;
        int          n = 0;
        int          e0;
        e0 = err_cnt;
        wait_release(tag);
        repeat (20) tick();
        bits[0] = ps2_data_in;
        for (int e = 1; e <= 10; e++) begin
            dev_cycle(b);
            bits[e] = b;
        end
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (HP) tick();
        dev_clk = 1'b0;
        repeat (HP) tick();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        while (!tx_done && n < 300) begin tick(); n++; end
        tx_data = next_data;
        check({tag, " tx_done"}, 32'(tx_done), 1);
        check({tag, " start bit"}, 32'(bits[0]), 0);
        check({tag, " data byte"}, 32'(bits[8:1]), 32'(exp_byte));
        check({tag, " parity"}, 32'(bits[9]), 32'(exp_par));
        check({tag, " stop bit"}, 32'(bits[10]), 1);
        check({tag, " ack_ok"}, 32'(tx_ack_ok), 32'(ack));
        check({tag, " ready at done"}, 32'(tx_ready), 1);
        check({tag, " no error"}, err_cnt, e0);
        tick();
        check({tag, " ack_ok held"}, 32'(tx_ack_ok), 32'(ack));
    endtask

    typedef struct {
        logic [7:0] din;
        logic       par;
        logic       ack;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        logic        b;
        int          n;
        int          d0;
        int          e0;
        int unsigned dt;

        tbl[0] = '{din: 8'hED, par: 1'b1, ack: 1'b1};
        tbl[1] = '{din: 8'h01, par: 1'b0, ack: 1'b1};
        tbl[2] = '{din: 8'h00, par: 1'b1, ack: 1'b0};
        tbl[3] = '{din: 8'hFF, par: 1'b1, ack: 1'b1};
        tbl[4] = '{din: 8'h80, par: 1'b0, ack: 1'b0};

        rst = 1'b1;
        repeat (4) tick();
        check("rst clk_oe", 32'(ps2_clk_oe), 0);
        check("rst data_oe", 32'(ps2_data_oe), 0);
        check("rst tx_done", 32'(tx_done), 0);
        check("rst tx_ack_ok", 32'(tx_ack_ok), 0);
        check("rst tx_error", 32'(tx_error), 0);
        check("rst busy", 32'(busy), 0);
        check("rst tx_ready", 32'(tx_ready), 1);
        rst = 1'b0;
        repeat (20) tick();
        check("idle clk_oe", 32'(ps2_clk_oe), 0);

        for (int i = 0; i < 5; i++) begin
            pulse_send(tbl[i].din);
            run_frame($sformatf("vec%0d", i), tbl[i].din, tbl[i].par, tbl[i].ack, 8'h00);
            repeat (10) tick();
        end

        // Back-to-back: tx_valid held; second byte taken only once the first completes.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        run_frame("b2b first", 8'h00, 1'b1, 1'b1, 8'hFF);
        check("b2b second accepted", 32'(busy), 1);
        check("b2b second inhibit", 32'(ps2_clk_oe), 1);
        tx_valid = 1'b0;
        run_frame("b2b second", 8'hFF, 1'b1, 1'b1, 8'h00);
        check("b2b done count", done_cnt, 7);
        repeat (10) tick();

        // Device never clocks after release.
        d0 = done_cnt;
        pulse_send(8'h01);
        wait_release("start_to");
        n = 0;
        while (!tx_error && n < int'(ST) + 100) begin tick(); n++; end
        check("start_to tx_error", 32'(tx_error), 1);
        dt = cyc - clk_rel_cyc;
        check("start_to delay", dt, ST);
        check("start_to clk_oe", 32'(ps2_clk_oe), 0);
        check("start_to data_oe", 32'(ps2_data_oe), 0);
        check("start_to tx_done", 32'(tx_done), 0);
        tick();
        check("start_to ready after", 32'(tx_ready), 1);
        check("start_to busy after", 32'(busy), 0);
        check("start_to no done", done_cnt, d0);
        repeat (10) tick();

        // Device stops after five clock edges.
        d0 = done_cnt;
        pulse_send(8'hED);
        wait_release("stall");
        repeat (20) tick();
        for (int e = 0; e < 5; e++) dev_cycle(b);
        n = 0;
        while (!tx_error && n < int'(FT) + 100) begin tick(); n++; end
        check("stall tx_error", 32'(tx_error), 1);
        dt = cyc - dat_fall_cyc;
        check("stall delay", dt, FT - 1);
        check("stall clk_oe", 32'(ps2_clk_oe), 0);
        check("stall data_oe", 32'(ps2_data_oe), 0);
        tick();
        check("stall ready after", 32'(tx_ready), 1);
        check("stall no done", done_cnt, d0);
        repeat (10) tick();

        // Short clock glitches must not advance the bit, then reset mid-frame.
        pulse_send(8'h65);
        wait_release("glitch");
        repeat (20) tick();
        dev_cycle(b);
        check("glitch bit0", 32'(b), 1);
        dev_clk = 1'b0;
        repeat (3) tick();
        dev_clk = 1'b1;
        repeat (20) tick();
        check("glitch data_oe kept", 32'(ps2_data_oe), 0);
        dev_clk = 1'b0;
        repeat (3) tick();
        dev_clk = 1'b1;
        repeat (20) tick();
        dev_cycle(b);
        check("glitch bit1", 32'(b), 0);
        dev_cycle(b);
        check("glitch bit2", 32'(b), 1);
        dev_clk = 1'b0;
        repeat (20) tick();
        check("edge4 drives bit3", 32'(ps2_data_oe), 1);
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        tick();
        check("midrst clk_oe", 32'(ps2_clk_oe), 0);
        check("midrst data_oe", 32'(ps2_data_oe), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst ready", 32'(tx_ready), 1);
        check("midrst tx_done", 32'(tx_done), 0);
        check("midrst tx_error", 32'(tx_error), 0);
        rst = 1'b0;
        repeat (20) tick();
        dev_clk = 1'b1;
        repeat (30) tick();
        check("midrst no done", done_cnt, d0);
        check("midrst no error", err_cnt, e0);
        check("midrst idle", 32'(busy), 0);

        check("done/error overlap", overlap_cnt, 0);
        check("ready vs busy", ready_busy_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
